// File: rtl/axi_cpu_master_port.sv
// CPU/cache-side burst request to AXI4 INCR master port.
// One transaction in flight: AR then R, or AW then W then B.
module axi_cpu_master_port #(
  parameter logic [3:0] MASTER_ID = 4'd0,
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  // CPU/cache request side
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        wr_strb,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              resp_valid,
  output logic [1:0]        resp_err,
  // AXI write address channel
  output logic [3:0]        m_awid,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [3:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  output logic              m_awvalid,
  input  logic              m_awready,
  // AXI write data channel
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  // AXI write response channel
  input  logic [3:0]        m_bid,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  // AXI read address channel
  output logic [3:0]        m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [3:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  // AXI read data channel
  input  logic [3:0]        m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready
);

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        len;
  logic [3:0]        cnt;
  logic [1:0]        err;
  logic              bad;
  logic              arvalid_q;
  logic              awvalid_q;
  logic              rready_q;
  logic              bready_q;

  // bad records an RID mismatch or a beat beyond len seen before RLAST
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      len        <= '0;
      cnt        <= '0;
      err        <= '0;
      bad        <= 1'b0;
      arvalid_q  <= 1'b0;
      awvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      bready_q   <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr <= req_addr;
            len  <= req_len;
            cnt  <= '0;
            err  <= '0;
            bad  <= 1'b0;
            if (req_write) begin
              state     <= AW;
              awvalid_q <= 1'b1;
            end else begin
              state     <= AR;
              arvalid_q <= 1'b1;
            end
          end
        end
        AR: begin
          if (m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= R;
          end
        end
        R: begin
          if (m_rvalid) begin
            if (m_rlast) begin
              rready_q   <= 1'b0;
              state      <= IDLE;
              resp_valid <= 1'b1;
              resp_err   <= (bad || m_rid != MASTER_ID || cnt != len) ? 2'b10 : (err | m_rresp);
            end else begin
              err <= err | m_rresp;
              if (m_rid != MASTER_ID || cnt == len) bad <= 1'b1;
              if (cnt != len) cnt <= cnt + 4'd1;
            end
          end
        end
        AW: begin
          if (m_awready) begin
            awvalid_q <= 1'b0;
            state     <= W;
          end
        end
        W: begin
          if (wr_valid && m_wready) begin
            if (cnt == len) begin
              state    <= B;
              bready_q <= 1'b1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        B: begin
          if (m_bvalid) begin
            bready_q   <= 1'b0;
            state      <= IDLE;
            resp_valid <= 1'b1;
            resp_err   <= (m_bid != MASTER_ID) ? 2'b10 : (err | m_bresp);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE) && !rst;

  assign m_arid    = MASTER_ID;
  assign m_araddr  = addr;
  assign m_arlen   = len;
  assign m_arsize  = 3'b010;
  assign m_arburst = 2'b01;
  assign m_arvalid = arvalid_q && !rst;

  assign m_awid    = MASTER_ID;
  assign m_awaddr  = addr;
  assign m_awlen   = len;
  assign m_awsize  = 3'b010;
  assign m_awburst = 2'b01;
  assign m_awvalid = awvalid_q && !rst;

  // Write data is a pass-through gated to the W state only
  assign m_wvalid  = (state == W) && wr_valid && !rst;
  assign wr_ready  = (state == W) && m_wready && !rst;
  assign m_wdata   = wr_data;
  assign m_wstrb   = wr_strb;
  assign m_wlast   = (state == W) && (cnt == len);

  assign m_bready  = bready_q && !rst;

  assign m_rready  = rready_q && !rst;
  assign rd_valid  = rready_q && m_rvalid && !rst;
  assign rd_data   = m_rdata;
  assign rd_last   = rready_q && m_rlast && !rst;

endmodule

// File: tb/tb_axi_cpu_master_port.sv
// Self-checking bench for axi_cpu_master_port: scripted scenarios plus
// randomized bursts against a transaction-level response model.
module tb_axi_cpu_master_port;

  localparam logic [3:0] MID = 4'd5;

  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_valid, rd_last, resp_valid;
  logic [31:0] rd_data;
  logic [1:0]  resp_err;
  logic [3:0]  m_awid, m_awlen, m_wstrb, m_bid, m_arid, m_arlen, m_rid;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awsize, m_arsize;
  logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic        m_bvalid, m_bready, m_arvalid, m_arready;
  logic        m_rlast, m_rvalid, m_rready;

  int checks = 0;
  int failures = 0;

  logic [1:0] beat_resp [0:31];
  logic [3:0] beat_id   [0:31];

  int          obs_lat, obs_acycles, obs_unstable, obs_beats, obs_last_idx;
  int          obs_data_err, obs_rready_bad, obs_idle_bad, obs_early_w;
  int          obs_wv_bad, obs_wlast_bad, obs_bready_bad, obs_inactive_bad;
  int          obs_resp_lat, obs_resp_pulse;
  logic [31:0] obs_addr;
  logic [3:0]  obs_len, obs_id;
  logic [2:0]  obs_size;
  logic [1:0]  obs_burst, obs_resp_err, obs_err_hold;
  logic        obs_ready_end;
  bit          obs_timeout;

  axi_cpu_master_port #(.MASTER_ID(MID), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_obs();
    obs_lat = -1; obs_acycles = 0; obs_unstable = 0; obs_beats = 0; obs_last_idx = -1;
    obs_data_err = 0; obs_rready_bad = 0; obs_idle_bad = 0; obs_early_w = 0;
    obs_wv_bad = 0; obs_wlast_bad = 0; obs_bready_bad = 0; obs_inactive_bad = 0;
    obs_resp_lat = -1; obs_resp_pulse = 0; obs_resp_err = 2'bxx; obs_err_hold = 2'bxx;
    obs_ready_end = 1'b0; obs_timeout = 0;
    obs_addr = '0; obs_len = '0; obs_id = '0; obs_size = '0; obs_burst = '0;
  endtask

  // Watches four cycles after the final handshake for the completion pulse
  task automatic wait_completion();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        obs_resp_pulse++;
        if (obs_resp_lat < 0) begin
          obs_resp_lat = c;
          obs_resp_err = resp_err;
        end
      end
      obs_err_hold  = resp_err;
      obs_ready_end = req_ready;
      @(posedge clk); #1;
    end
  endtask

  // Read burst driver acting as AXI slave; beat_resp/beat_id set by caller
  task automatic run_read(input logic [31:0] a, input logic [3:0] l,
                          input int ar_delay, input int nbeats);
    bit done;
    logic [31:0] d;
    clear_obs();
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = l;
    @(posedge clk); #1;
    req_valid = 1'b0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      m_arready = (obs_acycles >= ar_delay);
      @(negedge clk);
      if (m_awvalid || m_wvalid || m_bready || m_rready) obs_inactive_bad++;
      if (m_arvalid) begin
        if (obs_acycles == 0) begin
          obs_lat = c; obs_addr = m_araddr; obs_len = m_arlen;
          obs_id = m_arid; obs_size = m_arsize; obs_burst = m_arburst;
        end else if (m_araddr !== obs_addr || m_arlen !== obs_len) begin
          obs_unstable++;
        end
        obs_acycles++;
        done = m_arready;
      end
      @(posedge clk); #1;
    end
    m_arready = 1'b0;
    if (!done) begin
      obs_timeout = 1;
      return;
    end
    for (int b = 0; b < nbeats; b++) begin
      m_rvalid = 1'b0; m_rlast = 1'b1; m_rdata = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        if (rd_valid) obs_idle_bad++;
        if (!m_rready) obs_rready_bad++;
        @(posedge clk); #1;
      end
      d = $urandom;
      m_rvalid = 1'b1; m_rdata = d; m_rresp = beat_resp[b]; m_rid = beat_id[b];
      m_rlast = (b == nbeats - 1);
      @(negedge clk);
      if (!m_rready) obs_rready_bad++;
      if (m_arvalid || m_awvalid || m_bready) obs_inactive_bad++;
      if (rd_valid) begin
        obs_beats++;
        if (rd_data !== d) obs_data_err++;
        if (rd_last) obs_last_idx = b;
      end
      @(posedge clk); #1;
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    wait_completion();
  endtask

  // Write burst driver acting as AXI slave and CPU data source
  task automatic run_write(input logic [31:0] a, input logic [3:0] l, input int aw_delay,
                           input int b_delay, input logic [1:0] bresp, input logic [3:0] bid,
                           input bit skip_req);
    bit done;
    int beat;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    clear_obs();
    for (int i = 0; i < 16; i++) begin
      wd[i] = $urandom;
      ws[i] = 4'($urandom);
    end
    if (!skip_req) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = l;
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      m_awready = (obs_acycles >= aw_delay);
      wr_valid = 1'b1; wr_data = wd[0]; wr_strb = ws[0]; m_wready = 1'b1;
      @(negedge clk);
      if (m_wvalid || wr_ready) obs_early_w++;
      if (m_arvalid || m_rready || m_bready) obs_inactive_bad++;
      if (m_awvalid) begin
        if (obs_acycles == 0) begin
          obs_lat = c; obs_addr = m_awaddr; obs_len = m_awlen;
          obs_id = m_awid; obs_size = m_awsize; obs_burst = m_awburst;
        end else if (m_awaddr !== obs_addr || m_awlen !== obs_len) begin
          obs_unstable++;
        end
        obs_acycles++;
        done = m_awready;
      end
      @(posedge clk); #1;
    end
    m_awready = 1'b0; wr_valid = 1'b0; m_wready = 1'b0;
    if (!done) begin
      obs_timeout = 1;
      return;
    end
    beat = 0;
    for (int c = 0; c < 100 && beat <= int'(l); c++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      m_wready = (c != 0) && ($urandom_range(0, 3) != 0);
      wr_data = wd[beat]; wr_strb = ws[beat];
      @(negedge clk);
      if (m_wvalid !== wr_valid || wr_ready !== m_wready) obs_wv_bad++;
      if (m_awvalid || m_bready || m_arvalid) obs_inactive_bad++;
      if (m_wvalid && m_wready) begin
        if (m_wdata !== wd[beat] || m_wstrb !== ws[beat]) obs_data_err++;
        if (m_wlast !== (beat == int'(l))) obs_wlast_bad++;
        beat++;
      end
      @(posedge clk); #1;
    end
    obs_beats = beat;
    if (beat <= int'(l)) begin
      obs_timeout = 1;
      wr_valid = 1'b0; m_wready = 1'b0;
      return;
    end
    for (int k = 0; k <= b_delay; k++) begin
      wr_valid = 1'b1; m_wready = 1'b1;
      m_bvalid = (k == b_delay); m_bresp = bresp; m_bid = bid;
      @(negedge clk);
      if (!m_bready) obs_bready_bad++;
      if (m_wvalid || wr_ready) obs_inactive_bad++;
      @(posedge clk); #1;
    end
    m_bvalid = 1'b0; wr_valid = 1'b0; m_wready = 1'b0;
    wait_completion();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_valid = 1'b1; m_rvalid = 1'b1; m_bvalid = 1'b1; m_wready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_req_ready got=%b exp=0", req_ready); end
    checks++; if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready} !== 5'b0) begin failures++; $display("[TB] FAIL rst_axi_handshake got=%b exp=00000", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}); end
    checks++; if ({wr_ready, rd_valid} !== 2'b0) begin failures++; $display("[TB] FAIL rst_cpu_handshake got=%b exp=00", {wr_ready, rd_valid}); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_err !== 2'b00) begin failures++; $display("[TB] FAIL rst_resp_err got=%b exp=00", resp_err); end
    wr_valid = 1'b0; m_rvalid = 1'b0; m_bvalid = 1'b0; m_wready = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL idle_req_ready got=%b exp=1", req_ready); end
    checks++; if ({rd_valid, m_arvalid, m_awvalid} !== 3'b0) begin failures++; $display("[TB] FAIL idle_outputs got=%b exp=000", {rd_valid, m_arvalid, m_awvalid}); end
    @(posedge clk); #1;
  endtask

  task automatic test_read_basic();
    for (int b = 0; b < 32; b++) begin beat_resp[b] = 2'b00; beat_id[b] = MID; end
    run_read(32'h0000_1000, 4'd3, 2, 4);
    checks++; if (obs_timeout !== 1'b0) begin failures++; $display("[TB] FAIL rd_timeout got=%0d exp=0", obs_timeout); end
    checks++; if (obs_lat !== 0) begin failures++; $display("[TB] FAIL rd_ar_latency got=%0d exp=0", obs_lat); end
    checks++; if (obs_acycles !== 3) begin failures++; $display("[TB] FAIL rd_arvalid_cycles got=%0d exp=3", obs_acycles); end
    checks++; if (obs_unstable !== 0) begin failures++; $display("[TB] FAIL rd_ar_stable got=%0d exp=0", obs_unstable); end
    checks++; if (obs_addr !== 32'h0000_1000) begin failures++; $display("[TB] FAIL rd_araddr got=%h exp=00001000", obs_addr); end
    checks++; if ({obs_len, obs_id, obs_size, obs_burst} !== {4'd3, MID, 3'b010, 2'b01}) begin failures++; $display("[TB] FAIL rd_ar_fields got=%h/%h/%b/%b exp=3/%h/010/01", obs_len, obs_id, obs_size, obs_burst, MID); end
    checks++; if (obs_beats !== 4) begin failures++; $display("[TB] FAIL rd_beats got=%0d exp=4", obs_beats); end
    checks++; if (obs_last_idx !== 3) begin failures++; $display("[TB] FAIL rd_last_index got=%0d exp=3", obs_last_idx); end
    checks++; if (obs_data_err + obs_idle_bad + obs_rready_bad + obs_inactive_bad !== 0) begin failures++; $display("[TB] FAIL rd_datapath data=%0d idle=%0d rready=%0d inactive=%0d exp=0", obs_data_err, obs_idle_bad, obs_rready_bad, obs_inactive_bad); end
    checks++; if (obs_resp_lat !== 0 || obs_resp_pulse !== 1) begin failures++; $display("[TB] FAIL rd_resp_pulse lat=%0d pulses=%0d exp=0/1", obs_resp_lat, obs_resp_pulse); end
    checks++; if (obs_resp_err !== 2'b00 || obs_err_hold !== 2'b00) begin failures++; $display("[TB] FAIL rd_resp_err got=%b hold=%b exp=00", obs_resp_err, obs_err_hold); end
  endtask

  task automatic test_write_basic();
    run_write(32'h0001_0000, 4'd1, 1, 1, 2'b00, MID, 0);
    checks++; if (obs_timeout !== 1'b0) begin failures++; $display("[TB] FAIL wr_timeout got=%0d exp=0", obs_timeout); end
    checks++; if (obs_early_w !== 0) begin failures++; $display("[TB] FAIL wr_early_data got=%0d exp=0", obs_early_w); end
    checks++; if (obs_acycles !== 2 || obs_lat !== 0) begin failures++; $display("[TB] FAIL wr_awvalid cycles=%0d lat=%0d exp=2/0", obs_acycles, obs_lat); end
    checks++; if ({obs_addr, obs_len, obs_id, obs_size, obs_burst} !== {32'h0001_0000, 4'd1, MID, 3'b010, 2'b01}) begin failures++; $display("[TB] FAIL wr_aw_fields got=%h/%h/%h/%b/%b", obs_addr, obs_len, obs_id, obs_size, obs_burst); end
    checks++; if (obs_beats !== 2 || obs_data_err !== 0) begin failures++; $display("[TB] FAIL wr_data beats=%0d data_err=%0d exp=2/0", obs_beats, obs_data_err); end
    checks++; if (obs_wlast_bad !== 0) begin failures++; $display("[TB] FAIL wr_wlast got=%0d exp=0", obs_wlast_bad); end
    checks++; if (obs_wv_bad + obs_inactive_bad !== 0) begin failures++; $display("[TB] FAIL wr_passthrough wv=%0d inactive=%0d exp=0", obs_wv_bad, obs_inactive_bad); end
    checks++; if (obs_bready_bad !== 0) begin failures++; $display("[TB] FAIL wr_bready got=%0d exp=0", obs_bready_bad); end
    checks++; if (obs_resp_lat !== 0 || obs_resp_pulse !== 1) begin failures++; $display("[TB] FAIL wr_resp_pulse lat=%0d pulses=%0d exp=0/1", obs_resp_lat, obs_resp_pulse); end
    checks++; if (obs_resp_err !== 2'b00) begin failures++; $display("[TB] FAIL wr_resp_err got=%b exp=00", obs_resp_err); end
  endtask

  task automatic test_single_write();
    run_write(32'h0000_0040, 4'd0, 0, 2, 2'b10, MID, 0);
    checks++; if (obs_timeout !== 1'b0 || obs_beats !== 1) begin failures++; $display("[TB] FAIL w1_beats timeout=%0d beats=%0d exp=0/1", obs_timeout, obs_beats); end
    checks++; if (obs_wlast_bad !== 0 || obs_data_err !== 0) begin failures++; $display("[TB] FAIL w1_wlast wlast=%0d data=%0d exp=0/0", obs_wlast_bad, obs_data_err); end
    checks++; if (obs_bready_bad !== 0) begin failures++; $display("[TB] FAIL w1_bready got=%0d exp=0", obs_bready_bad); end
    checks++; if (obs_resp_err !== 2'b10 || obs_err_hold !== 2'b10) begin failures++; $display("[TB] FAIL w1_resp_err got=%b hold=%b exp=10", obs_resp_err, obs_err_hold); end
  endtask

  task automatic test_short_read();
    for (int b = 0; b < 32; b++) begin beat_resp[b] = 2'b00; beat_id[b] = MID; end
    run_read(32'h0000_2000, 4'd3, 0, 2);
    checks++; if (obs_timeout !== 1'b0 || obs_beats !== 2) begin failures++; $display("[TB] FAIL short_beats timeout=%0d beats=%0d exp=0/2", obs_timeout, obs_beats); end
    checks++; if (obs_resp_lat !== 0 || obs_resp_err !== 2'b10) begin failures++; $display("[TB] FAIL short_resp_err lat=%0d got=%b exp=0/10", obs_resp_lat, obs_resp_err); end
    checks++; if (obs_ready_end !== 1'b1) begin failures++; $display("[TB] FAIL short_idle req_ready=%b exp=1", obs_ready_end); end
  endtask

  task automatic test_reset_mid_burst();
    bit done;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_2400; req_len = 4'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    m_awready = 1'b1;
    done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      done = m_awvalid;
      @(posedge clk); #1;
    end
    m_awready = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL mid_aw_timeout got=%0d exp=1", done); end
    wr_valid = 1'b1; m_wready = 1'b1; wr_data = $urandom; wr_strb = 4'hF;
    @(negedge clk);
    checks++; if ({m_wvalid, m_wlast} !== 2'b10) begin failures++; $display("[TB] FAIL mid_first_beat wvalid/wlast got=%b exp=10", {m_wvalid, m_wlast}); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({m_wvalid, wr_ready, req_ready, m_awvalid} !== 4'b0) begin failures++; $display("[TB] FAIL mid_in_reset got=%b exp=0000", {m_wvalid, wr_ready, req_ready, m_awvalid}); end
    rst = 1'b0; wr_valid = 1'b0; m_wready = 1'b0;
    #1;
    checks++; if ({req_ready, m_bready, m_wlast} !== 3'b100) begin failures++; $display("[TB] FAIL mid_idle req_ready/bready/wlast got=%b exp=100", {req_ready, m_bready, m_wlast}); end
    @(posedge clk); #1;
    for (int b = 0; b < 32; b++) begin beat_resp[b] = 2'b00; beat_id[b] = MID; end
    run_read(32'h0000_3000, 4'd2, 0, 3);
    checks++; if (obs_timeout !== 1'b0 || obs_beats !== 3) begin failures++; $display("[TB] FAIL mid_read_after timeout=%0d beats=%0d exp=0/3", obs_timeout, obs_beats); end
    checks++; if (obs_resp_lat !== 0 || obs_resp_err !== 2'b00) begin failures++; $display("[TB] FAIL mid_read_resp lat=%0d err=%b exp=0/00", obs_resp_lat, obs_resp_err); end
  endtask

  task automatic test_back_to_back();
    bit done;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_4000; req_len = 4'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    m_arready = 1'b1;
    done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      done = m_arvalid;
      @(posedge clk); #1;
    end
    m_arready = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ar_timeout got=%0d exp=1", done); end
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = MID; m_rresp = 2'b00; m_rdata = $urandom;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_5000; req_len = 4'd0;
    @(negedge clk);
    checks++; if ({req_ready, rd_valid, rd_last} !== 3'b011) begin failures++; $display("[TB] FAIL b2b_busy req_ready/rd_valid/rd_last got=%b exp=011", {req_ready, rd_valid, rd_last}); end
    @(posedge clk); #1;
    m_rvalid = 1'b0; m_rlast = 1'b0;
    @(negedge clk);
    checks++; if ({resp_valid, req_ready} !== 2'b11) begin failures++; $display("[TB] FAIL b2b_accept resp_valid/req_ready got=%b exp=11", {resp_valid, req_ready}); end
    checks++; if (resp_err !== 2'b00) begin failures++; $display("[TB] FAIL b2b_read_err got=%b exp=00", resp_err); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (m_awvalid !== 1'b1 || m_awaddr !== 32'h0000_5000) begin failures++; $display("[TB] FAIL b2b_awvalid got=%b addr=%h exp=1/00005000", m_awvalid, m_awaddr); end
    @(posedge clk); #1;
    run_write(32'h0000_5000, 4'd0, 0, 0, 2'b01, MID, 1);
    checks++; if (obs_timeout !== 1'b0 || obs_beats !== 1 || obs_wlast_bad !== 0) begin failures++; $display("[TB] FAIL b2b_write timeout=%0d beats=%0d wlast=%0d exp=0/1/0", obs_timeout, obs_beats, obs_wlast_bad); end
    checks++; if (obs_resp_err !== 2'b01) begin failures++; $display("[TB] FAIL b2b_write_err got=%b exp=01", obs_resp_err); end
  endtask

  // Expected error: OR of slave responses, overridden by 2'b10 on ID or length mismatch
  task automatic test_random();
    logic [31:0] a;
    logic [3:0]  l, bid;
    logic [1:0]  exp, bresp;
    int nb, r;
    bit bad;
    for (int it = 0; it < 10; it++) begin
      a = $urandom; a[1:0] = 2'b00;
      l = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        nb = int'(l) + 1;
        if ($urandom_range(0, 5) == 0 && l > 0) nb = $urandom_range(1, int'(l));
        exp = 2'b00; bad = 0;
        for (int b = 0; b < nb; b++) begin
          r = $urandom_range(0, 9);
          beat_resp[b] = (r < 7) ? 2'b00 : (r < 9) ? 2'b01 : 2'b10;
          beat_id[b] = ($urandom_range(0, 11) == 0) ? (MID ^ 4'h3) : MID;
          exp = exp | beat_resp[b];
          if (beat_id[b] != MID) bad = 1;
        end
        if (bad || nb != int'(l) + 1) exp = 2'b10;
        run_read(a, l, $urandom_range(0, 2), nb);
        checks++; if (obs_timeout !== 1'b0 || obs_beats !== nb || obs_data_err !== 0) begin failures++; $display("[TB] FAIL rand_rd%0d timeout=%0d beats=%0d/%0d data=%0d", it, obs_timeout, obs_beats, nb, obs_data_err); end
        checks++; if (obs_addr !== a || obs_len !== l) begin failures++; $display("[TB] FAIL rand_rd%0d_ar addr=%h/%h len=%0d/%0d", it, obs_addr, a, obs_len, l); end
        checks++; if (obs_resp_lat !== 0 || obs_resp_err !== exp) begin failures++; $display("[TB] FAIL rand_rd%0d_err lat=%0d got=%b exp=%b", it, obs_resp_lat, obs_resp_err, exp); end
      end else begin
        bresp = 2'($urandom_range(0, 3));
        bid = ($urandom_range(0, 3) == 0) ? (MID ^ 4'h8) : MID;
        exp = (bid != MID) ? 2'b10 : bresp;
        run_write(a, l, $urandom_range(0, 2), $urandom_range(0, 2), bresp, bid, 0);
        checks++; if (obs_timeout !== 1'b0 || obs_beats !== int'(l) + 1 || obs_data_err !== 0 || obs_wlast_bad !== 0) begin failures++; $display("[TB] FAIL rand_wr%0d timeout=%0d beats=%0d len=%0d data=%0d wlast=%0d", it, obs_timeout, obs_beats, l, obs_data_err, obs_wlast_bad); end
        checks++; if (obs_addr !== a || obs_len !== l || obs_early_w !== 0) begin failures++; $display("[TB] FAIL rand_wr%0d_aw addr=%h/%h len=%0d/%0d early=%0d", it, obs_addr, a, obs_len, l, obs_early_w); end
        checks++; if (obs_resp_lat !== 0 || obs_resp_err !== exp) begin failures++; $display("[TB] FAIL rand_wr%0d_err lat=%0d got=%b exp=%b", it, obs_resp_lat, obs_resp_err, exp); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; wr_strb = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
    m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    test_reset();
    test_read_basic();
    test_write_basic();
    test_single_write();
    test_short_read();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_cpu_master_port.md
Name: axi_cpu_master_port

Overview:
- Converts a simple single-outstanding burst request from the CPU/cache side into AXI4 INCR read or write bursts.
- Drives the master modport of the AXI master interface toward the interconnect.
- Sits between the L1 cache controller (upstream) and the AXI bridge (downstream).
- Handles one transaction at a time: AR then R, or AW then W then B, in strict order.

Parameters:
- MASTER_ID, 4'd0, value driven on ARID/AWID; width `AXI_ID_BITS.
- ADDR_W, 32, request address width; equals `AXI_ADDR_BITS.
- DATA_W, 32, data width; equals `AXI_DATA_BITS.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when high together with req_valid.
- req_write  input  1  1 = write burst, 0 = read burst.
- req_addr  input  ADDR_W  start byte address; word-aligned.
- req_len  input  4  beats minus 1 (0..15); goes to AxLEN.
- wr_valid  input  1  write beat available.
- wr_ready  output  1  write beat consumed.
- wr_data  input  DATA_W  write beat data.
- wr_strb  input  4  write beat byte strobes.
- rd_valid  output  1  read beat valid.
- rd_data  output  DATA_W  read beat data.
- rd_last  output  1  final read beat.
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  2  accumulated AXI response for the completed burst.
- m  modport  -  AXI_interface_master.master (AW, W, B, AR and R channels).

Behaviour:
- FSM states: IDLE, AR, R, AW, W, B.
- Reset: state IDLE, beat counter 0, latched addr/len 0.
  - While rst is high, req_ready=0; all AXI VALID/READY outputs 0, resp_valid=0, resp_err=0.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch addr, len, write; clear counter and error.
  - Next state is AW if write, else AR.
  - Request and resp_valid may coincide; the new request is accepted in that cycle.
- AR:
  - ARVALID=1; ARADDR/ARLEN from the latched values; ARID=MASTER_ID; ARSIZE=3'b010; ARBURST=2'b01.
  - Signals are stable until ARREADY. ARVALID rises the cycle after acceptance.
  - On ARREADY go to R.
- R:
  - RREADY=1 continuously; the CPU side cannot backpressure reads.
  - rd_valid=RVALID; rd_data=RDATA; rd_last=RLAST (combinational pass-through).
  - Each beat increments the counter; resp_err |= RRESP.
  - On RLAST beat: if counter != len, or RID != MASTER_ID on any beat, set resp_err=2'b10. Go to IDLE.
- AW:
  - AWVALID=1 with fields as in AR. On AWREADY go to W.
  - Write data is never issued before the AW handshake.
- W:
  - WVALID=wr_valid; wr_ready=WREADY; WDATA/WSTRB pass through.
  - WLAST=(counter==len).
  - Each WVALID&&WREADY increments the counter; the last beat goes to B.
- B:
  - BREADY=1. On BVALID: resp_err |= BRESP; BID mismatch forces 2'b10. Go to IDLE.
- Completion: resp_valid is a registered 1-cycle pulse in the cycle after the final R or B handshake.
  - resp_err is valid with resp_valid and holds until the next completion.
- Inactive outputs are 0 outside their state: ARVALID, AWVALID, WVALID, RREADY, BREADY, wr_ready, rd_valid.
- Latency:
  - Read: request accept → ARVALID is 1 cycle; last R beat → resp_valid is 1 cycle.
  - Write: last W beat → BREADY same cycle as entry to B.
- Boundaries:
  - req_len=0 gives a single beat with WLAST on the first beat.
  - Counter is 4 bits; no wrap beyond len.
  - 4 KB crossing is not checked; the requester guarantees it.
  - Reset mid-burst abandons the transaction; VALIDs drop the next cycle.
- Unused inputs are ignored outside their states: RVALID, BVALID, wr_valid.

Test Plan:
1. Read, addr=0x0000_1000, len=3; slave returns 4 beats OKAY with ARREADY delayed 2 cycles → ARVALID held 3 cycles; ARLEN=3; rd_valid 4 times with rd_last on the 4th; resp_valid 1 cycle later; resp_err=0.
2. Write, addr=0x0001_0000, len=1; wr_valid toggles; WREADY stalls 1 cycle → WLAST only on the 2nd beat; WDATA/WSTRB match; BRESP=OKAY gives resp_err=0.
3. Single-beat write, len=0, BRESP=2'b10 → WLAST on the first beat; resp_err=2'b10.
4. Read len=3 where the slave asserts RLAST on beat 2 → resp_err=2'b10; FSM back to IDLE; req_ready=1.
5. rst asserted during W after 1 of 4 beats → next cycle WVALID=0, state IDLE; a following read request completes normally.
6. Back-to-back requests, new req_valid held high → second request accepted in the resp_valid cycle; ARVALID/AWVALID the next cycle.
